// File: rtl/write_back.sv
// write_back: commit stage; waits on execute, writes the 32x32 regfile, selects next PC. Optional `RETIRE_CNT_EN retire counter.
// Latency: pc_valid two cycles after issue at best; WAIT bounded by TIMEOUT (bus_err on expiry). Issue while busy is dropped.
module write_back #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [31:0] pc,
  input  logic [31:0] wdata,
  input  logic        exe_fin,
  input  logic        b_en,
  input  logic [31:0] jmp_addr,
  input  logic [31:0] jalr_target,
  input  logic [4:0]  rs1_idx,
  input  logic [4:0]  rs2_idx,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic [31:0] next_pc,
  output logic        pc_valid,
  output logic        reset_memory,
  output logic        busy,
`ifdef RETIRE_CNT_EN
  output logic [63:0] retired,
`endif
  output logic        bus_err
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [15:0] TMO_LIM  = 16'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_COMMIT} state_t;

  state_t      state_q, state_d;
  logic [6:0]  op_q, op_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] cnt_q, cnt_d;
  logic        tmo_q, tmo_d;
  logic [31:0] next_pc_q, next_pc_d;
  logic        pc_valid_q, pc_valid_d;
  logic        reset_memory_q, reset_memory_d;
  logic        bus_err_q, bus_err_d;
  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic [31:0] pc_plus4;
  logic        done_cond;
`ifdef RETIRE_CNT_EN
  logic [63:0] retired_q, retired_d;
`endif

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    case (op_q)
      OP_ALU, OP_ALUI, OP_LOAD, OP_STORE: done_cond = exe_fin;
      default:                            done_cond = 1'b1;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    rd_d           = rd_q;
    pc_d           = pc_q;
    cnt_d          = cnt_q;
    tmo_d          = tmo_q;
    next_pc_d      = next_pc_q;
    pc_valid_d     = 1'b0;
    reset_memory_d = 1'b0;
    bus_err_d      = 1'b0;
    regs_d         = regs_q;
`ifdef RETIRE_CNT_EN
    retired_d      = retired_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (issue) begin
          state_d = S_WAIT;
          op_d    = opcode;
          rd_d    = rd;
          pc_d    = pc;
          cnt_d   = 16'd0;
          tmo_d   = 1'b0;
        end
      end
      S_WAIT: begin
        if (done_cond) begin
          state_d = S_COMMIT;
        end else if (cnt_q == TMO_LIM) begin
          state_d = S_COMMIT;
          tmo_d   = 1'b1;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_COMMIT: begin
        state_d        = S_IDLE;
        pc_valid_d     = 1'b1;
        reset_memory_d = 1'b1;
        bus_err_d      = tmo_q;
        next_pc_d      = pc_plus4;
        if (!tmo_q) begin
          case (op_q)
            OP_JAL:    next_pc_d = jmp_addr;
            OP_JALR:   next_pc_d = jalr_target & ~32'h1;
            OP_BRANCH: next_pc_d = b_en ? jmp_addr : pc_plus4;
            default:   next_pc_d = pc_plus4;
          endcase
          // x0 stays hard-wired to zero
          if (rd_q != 5'd0) begin
            case (op_q)
              OP_LUI, OP_ALU, OP_ALUI, OP_LOAD: regs_d[rd_q] = wdata;
              OP_JAL, OP_JALR:                  regs_d[rd_q] = pc_plus4;
              default: ;
            endcase
          end
`ifdef RETIRE_CNT_EN
          retired_d = retired_q + 64'd1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      op_q           <= 7'd0;
      rd_q           <= 5'd0;
      pc_q           <= 32'd0;
      cnt_q          <= 16'd0;
      tmo_q          <= 1'b0;
      next_pc_q      <= RESET_PC;
      pc_valid_q     <= 1'b0;
      reset_memory_q <= 1'b0;
      bus_err_q      <= 1'b0;
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
`ifdef RETIRE_CNT_EN
      retired_q      <= 64'd0;
`endif
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      rd_q           <= rd_d;
      pc_q           <= pc_d;
      cnt_q          <= cnt_d;
      tmo_q          <= tmo_d;
      next_pc_q      <= next_pc_d;
      pc_valid_q     <= pc_valid_d;
      reset_memory_q <= reset_memory_d;
      bus_err_q      <= bus_err_d;
      regs_q         <= regs_d;
`ifdef RETIRE_CNT_EN
      retired_q      <= retired_d;
`endif
    end
  end

  assign rs1_data     = (rs1_idx == 5'd0) ? 32'd0 : regs_q[rs1_idx];
  assign rs2_data     = (rs2_idx == 5'd0) ? 32'd0 : regs_q[rs2_idx];
  assign next_pc      = next_pc_q;
  assign pc_valid     = pc_valid_q;
  assign reset_memory = reset_memory_q;
  assign bus_err      = bus_err_q;
  assign busy         = (state_q != S_IDLE);
`ifdef RETIRE_CNT_EN
  assign retired      = retired_q;
`endif

endmodule

// File: tb/tb_write_back.sv
// Randomized bench for write_back against a rule-level commit model (TIMEOUT=4).
module tb_write_back;

  localparam int TMO = 4;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_ILL    = 7'b1111111;

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] wdata;
    int          fin;      // WAIT cycles before exe_fin rises; -1 = never
    logic        b_en;
    logic [31:0] jmp;
    logic [31:0] jalr;
    bit          reissue;
  } instr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue = 1'b0;
  logic [6:0]  opcode = '0;
  logic [4:0]  rd = '0;
  logic [31:0] pc = '0;
  logic [31:0] wdata = '0;
  logic        exe_fin = 1'b0;
  logic        b_en = 1'b0;
  logic [31:0] jmp_addr = '0;
  logic [31:0] jalr_target = '0;
  logic [4:0]  rs1_idx = '0;
  logic [4:0]  rs2_idx = '0;
  logic [31:0] rs1_data, rs2_data, next_pc;
  logic        pc_valid, reset_memory, busy, bus_err;
`ifdef RETIRE_CNT_EN
  logic [63:0] retired;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] mreg [32];

  always #5 clk = ~clk;

  write_back #(.RESET_PC(32'h0000_0000), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .issue(issue), .opcode(opcode), .rd(rd), .pc(pc),
    .wdata(wdata), .exe_fin(exe_fin), .b_en(b_en), .jmp_addr(jmp_addr),
    .jalr_target(jalr_target), .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .next_pc(next_pc),
    .pc_valid(pc_valid), .reset_memory(reset_memory), .busy(busy),
`ifdef RETIRE_CNT_EN
    .retired(retired),
`endif
    .bus_err(bus_err)
  );

  function automatic instr_t mk(logic [6:0] op, logic [4:0] r, logic [31:0] p, logic [31:0] wd,
                                int fin, logic be, logic [31:0] j, logic [31:0] jr, bit ri);
    instr_t t;
    t.op = op; t.rd = r; t.pc = p; t.wdata = wd; t.fin = fin;
    t.b_en = be; t.jmp = j; t.jalr = jr; t.reissue = ri;
    return t;
  endfunction

  function automatic instr_t rand_instr();
    instr_t t;
    case ($urandom_range(0, 9))
      0: t.op = OP_LUI;    1: t.op = OP_JAL;   2: t.op = OP_JALR;
      3: t.op = OP_BRANCH; 4: t.op = OP_LOAD;  5: t.op = OP_STORE;
      6: t.op = OP_ALUI;   7: t.op = OP_ALU;   8: t.op = OP_ILL;
      default: t.op = 7'b0010111;
    endcase
    t.rd = 5'($urandom); t.pc = $urandom; t.wdata = $urandom;
    t.fin = int'($urandom_range(0, 7)) - 1;
    t.b_en = 1'($urandom); t.jmp = $urandom; t.jalr = $urandom;
    t.reissue = ($urandom_range(0, 3) == 0);
    return t;
  endfunction

  // Expected commit derived from the architectural rules
  task automatic model(input instr_t t, output int lat, output logic err, output logic [31:0] npc,
                       output logic we, output logic [31:0] wval);
    bit needs_fin, tmo;
    logic [31:0] p4;
    p4 = t.pc + 32'd4;
    needs_fin = (t.op == OP_ALU) || (t.op == OP_ALUI) || (t.op == OP_LOAD) || (t.op == OP_STORE);
    tmo = needs_fin && !(t.fin >= 0 && t.fin <= TMO);
    lat = !needs_fin ? 2 : (tmo ? TMO + 2 : t.fin + 2);
    err = tmo;
    if (tmo)                   npc = p4;
    else if (t.op == OP_JAL)   npc = t.jmp;
    else if (t.op == OP_JALR)  npc = {t.jalr[31:1], 1'b0};
    else if (t.op == OP_BRANCH) npc = t.b_en ? t.jmp : p4;
    else                       npc = p4;
    we = !tmo && (t.rd != 0) &&
         (t.op inside {OP_LUI, OP_ALU, OP_ALUI, OP_LOAD, OP_JAL, OP_JALR});
    wval = (t.op == OP_JAL || t.op == OP_JALR) ? p4 : t.wdata;
  endtask

  task automatic drive(input instr_t t, output int lat, output logic [31:0] o_npc,
                       output logic o_err, output logic o_rm, output logic o_busy,
                       output logic o_after, output logic o_after_busy, output logic [31:0] o_old);
    bit got;
    @(negedge clk);
    issue = 1'b1; opcode = t.op; rd = t.rd; pc = t.pc; wdata = t.wdata;
    b_en = t.b_en; jmp_addr = t.jmp; jalr_target = t.jalr; exe_fin = 1'b0; rs1_idx = t.rd;
    @(negedge clk);
    o_busy = busy; o_old = rs1_data;
    lat = 0; got = 0;
    while (!got && lat < 300) begin
      issue = t.reissue && (lat <= 1);
      if (issue) begin opcode = 7'($urandom); rd = 5'($urandom); pc = $urandom; end
      exe_fin = (t.fin >= 0) && (lat >= t.fin);
      @(negedge clk);
      lat++;
      if (pc_valid) got = 1;
      else o_old = rs1_data;
    end
    issue = 1'b0; exe_fin = 1'b0;
    o_npc = next_pc; o_err = bus_err; o_rm = reset_memory;
    @(negedge clk);
    o_after = pc_valid | reset_memory | bus_err;
    o_after_busy = busy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
    @(negedge clk);
    rs1_idx = 5'd5; rs2_idx = 5'd31;
    #1;
    checks++; if (next_pc !== 32'h0) begin errors++; $display("FAIL reset next_pc got %h exp 0", next_pc); end
    checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL reset pc_valid got %b exp 0", pc_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b exp 0", busy); end
    checks++; if (reset_memory !== 1'b0) begin errors++; $display("FAIL reset reset_memory got %b exp 0", reset_memory); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL reset bus_err got %b exp 0", bus_err); end
    checks++; if (rs1_data !== 32'h0) begin errors++; $display("FAIL reset x5 got %h exp 0", rs1_data); end
    checks++; if (rs2_data !== 32'h0) begin errors++; $display("FAIL reset x31 got %h exp 0", rs2_data); end
  endtask

  task automatic test_directed();
    instr_t tbl [11];
    int lat, elat;
    logic [31:0] npc, enpc, old, eold, ewval;
    logic err, eerr, rm, bsy, aft, aftb, ewe;
    tbl[0]  = mk(OP_ALUI,   5'd5,  32'h100, 32'h1234, 0, 1'b0, 32'h0, 32'h0, 1'b0);
    tbl[1]  = mk(OP_BRANCH, 5'd7,  32'h200, 32'h5555, 0, 1'b1, 32'h180, 32'h0, 1'b0);
    tbl[2]  = mk(OP_BRANCH, 5'd7,  32'h200, 32'h5555, 0, 1'b0, 32'h180, 32'h0, 1'b0);
    tbl[3]  = mk(OP_JALR,   5'd1,  32'h300, 32'h9999, 0, 1'b0, 32'h0, 32'h401, 1'b0);
    tbl[4]  = mk(OP_LOAD,   5'd9,  32'h500, 32'h7777, -1, 1'b0, 32'h0, 32'h0, 1'b0);
    tbl[5]  = mk(OP_LUI,    5'd0,  32'h600, 32'hABCDE000, 0, 1'b0, 32'h0, 32'h0, 1'b1);
    tbl[6]  = mk(OP_LOAD,   5'd3,  32'h640, 32'hCAFE0003, TMO, 1'b0, 32'h0, 32'h0, 1'b0);
    tbl[7]  = mk(OP_JAL,    5'd31, 32'hFFFF_FFFC, 32'h1, 0, 1'b0, 32'h800, 32'h0, 1'b0);
    tbl[8]  = mk(OP_ILL,    5'd4,  32'h900, 32'hDEAD, 0, 1'b0, 32'h0, 32'h0, 1'b0);
    tbl[9]  = mk(OP_STORE,  5'd6,  32'hA00, 32'hBEEF, 2, 1'b0, 32'h0, 32'h0, 1'b0);
    tbl[10] = mk(OP_ALU,    5'd8,  32'hB00, 32'h0808, 3, 1'b0, 32'h0, 32'h0, 1'b1);
    for (int k = 0; k < 11; k++) begin
      model(tbl[k], elat, eerr, enpc, ewe, ewval);
      eold = mreg[tbl[k].rd];
      drive(tbl[k], lat, npc, err, rm, bsy, aft, aftb, old);
      if (ewe) mreg[tbl[k].rd] = ewval;
      rs2_idx = 5'($urandom);
      #1;
      checks++; if (lat != elat) begin errors++; $display("FAIL dir[%0d] latency got %0d exp %0d", k, lat, elat); end
      checks++; if (npc !== enpc) begin errors++; $display("FAIL dir[%0d] next_pc got %h exp %h", k, npc, enpc); end
      checks++; if (err !== eerr) begin errors++; $display("FAIL dir[%0d] bus_err got %b exp %b", k, err, eerr); end
      checks++; if (rm !== 1'b1) begin errors++; $display("FAIL dir[%0d] reset_memory got %b exp 1", k, rm); end
      checks++; if (bsy !== 1'b1) begin errors++; $display("FAIL dir[%0d] busy got %b exp 1", k, bsy); end
      checks++; if (aft !== 1'b0 || aftb !== 1'b0) begin errors++; $display("FAIL dir[%0d] pulse_drop got %b/%b exp 0/0", k, aft, aftb); end
      checks++; if (old !== eold) begin errors++; $display("FAIL dir[%0d] old_read got %h exp %h", k, old, eold); end
      checks++; if (rs1_data !== mreg[tbl[k].rd]) begin errors++; $display("FAIL dir[%0d] rd_read got %h exp %h", k, rs1_data, mreg[tbl[k].rd]); end
      checks++; if (rs2_data !== mreg[rs2_idx]) begin errors++; $display("FAIL dir[%0d] rs2_read got %h exp %h", k, rs2_data, mreg[rs2_idx]); end
    end
    // spot-check the scenario values directly
    rs1_idx = 5'd5; rs2_idx = 5'd1; #1;
    checks++; if (rs1_data !== 32'h1234) begin errors++; $display("FAIL x5_value got %h exp 1234", rs1_data); end
    checks++; if (rs2_data !== 32'h304) begin errors++; $display("FAIL x1_value got %h exp 304", rs2_data); end
    rs1_idx = 5'd9; rs2_idx = 5'd31; #1;
    checks++; if (rs1_data !== 32'h0) begin errors++; $display("FAIL x9_timeout got %h exp 0", rs1_data); end
    checks++; if (rs2_data !== 32'h0) begin errors++; $display("FAIL x31_wrap got %h exp 0", rs2_data); end
  endtask

  task automatic test_reset_abort();
    bit seen;
    @(negedge clk);
    issue = 1'b1; opcode = OP_LOAD; rd = 5'd6; pc = 32'h700; wdata = 32'h6666; exe_fin = 1'b0;
    @(negedge clk);
    issue = 1'b0;
    repeat (2) @(negedge clk);
    exe_fin = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; exe_fin = 1'b0;
    for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
    rs1_idx = 5'd5; rs2_idx = 5'd6; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort busy got %b exp 0", busy); end
    checks++; if (next_pc !== 32'h0) begin errors++; $display("FAIL abort next_pc got %h exp 0", next_pc); end
    checks++; if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin errors++; $display("FAIL abort regs got %h/%h exp 0/0", rs1_data, rs2_data); end
    seen = 0;
    repeat (10) begin @(negedge clk); if (pc_valid || reset_memory) seen = 1; end
    checks++; if (seen) begin errors++; $display("FAIL abort late_commit got 1 exp 0"); end
  endtask

  task automatic test_random_stream();
    instr_t t;
    int lat, elat;
    logic [31:0] npc, enpc, old, eold, ewval;
    logic err, eerr, rm, bsy, aft, aftb, ewe;
    for (int k = 0; k < 40; k++) begin
      t = rand_instr();
      model(t, elat, eerr, enpc, ewe, ewval);
      eold = mreg[t.rd];
      drive(t, lat, npc, err, rm, bsy, aft, aftb, old);
      if (ewe) mreg[t.rd] = ewval;
      rs2_idx = 5'($urandom);
      #1;
      checks++; if (lat != elat) begin errors++; $display("FAIL rnd[%0d] op=%h latency got %0d exp %0d", k, t.op, lat, elat); end
      checks++; if (npc !== enpc) begin errors++; $display("FAIL rnd[%0d] op=%h next_pc got %h exp %h", k, t.op, npc, enpc); end
      checks++; if (err !== eerr) begin errors++; $display("FAIL rnd[%0d] op=%h bus_err got %b exp %b", k, t.op, err, eerr); end
      checks++; if (rm !== 1'b1) begin errors++; $display("FAIL rnd[%0d] reset_memory got %b exp 1", k, rm); end
      checks++; if (aft !== 1'b0 || aftb !== 1'b0) begin errors++; $display("FAIL rnd[%0d] pulse_drop got %b/%b exp 0/0", k, aft, aftb); end
      checks++; if (old !== eold) begin errors++; $display("FAIL rnd[%0d] old_read got %h exp %h", k, old, eold); end
      checks++; if (rs1_data !== mreg[t.rd]) begin errors++; $display("FAIL rnd[%0d] op=%h rd_read got %h exp %h", k, t.op, rs1_data, mreg[t.rd]); end
      checks++; if (rs2_data !== mreg[rs2_idx]) begin errors++; $display("FAIL rnd[%0d] rs2_read got %h exp %h", k, rs2_data, mreg[rs2_idx]); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_abort();
    test_random_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
